// File: rtl/fft_acc_pll_ctrl_pkg.sv
// Shared definitions for the fft_acc PLL lock controller: state encoding,
// default timing constants and the shared counter sizing helper.
package fft_acc_pll_ctrl_pkg;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_SYNC_STAGES   = 2;

    typedef logic [2:0] state_t;

    localparam state_t PLL_RST   = 3'd0;
    localparam state_t WAIT_LOCK = 3'd1;
    localparam state_t STABILIZE = 3'd2;
    localparam state_t RUN       = 3'd3;
    localparam state_t FAULT     = 3'd4;

    // Width of the one counter shared by all timed states.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fft_acc_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module fft_acc_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fft_acc_pll_lock_ctrl.sv
// PLL reset/lock supervisor for the fft_acc clock tree: retries on timeout,
// debounces lock, and releases the accelerator reset once lock is stable.
//
// state     | meaning
// ----------+------------------------------------------------------------
// PLL_RST   | pll_rst held high for RST_CYCLES
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
// STABILIZE | lock must stay high for STABLE_CYCLES consecutive cycles
// RUN       | system released; any lock drop re-sequences the PLL
// FAULT     | all attempts exhausted; waits for sw_relock
module fft_acc_pll_lock_ctrl
    import fft_acc_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pll_locked,
    input  logic          sw_relock,
    output logic          pll_rst,
    output logic          sys_reset_n,
    output logic          ready,
    output logic          fault,
    output logic          lock_lost,
    output logic [RW-1:0] retry_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock is the first stable cycle.
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          locked_s;

    fft_acc_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_cnt   <= '0;
        end else if (sw_relock) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABILIZE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_MAX) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            state     <= PLL_RST;
                            retry_cnt <= retry_cnt + 1'b1;
                        end
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        sys_reset_n <= 1'b1;
                        ready       <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (!locked_s) begin
                        state       <= PLL_RST;
                        pll_rst     <= 1'b1;
                        sys_reset_n <= 1'b0;
                        ready       <= 1'b0;
                        lock_lost   <= 1'b1;
                        retry_cnt   <= '0;
                    end
                end
                FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    state       <= PLL_RST;
                    cnt         <= '0;
                    pll_rst     <= 1'b1;
                    sys_reset_n <= 1'b0;
                    ready       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_acc_pll_lock_ctrl.sv
// Scoreboard bench for fft_acc_pll_lock_ctrl: expected output vectors are
// queued per cycle as stimulus is driven and compared on the falling edge.
module tb_fft_acc_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_relock;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [1:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t sb[$];

    fft_acc_pll_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .SYNC_STAGES   (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sw_relock   (sw_relock),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .fault       (fault),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    wire [6:0] ov = {pll_rst, sys_reset_n, ready, fault, lock_lost, retry_cnt};

    // {pll_rst, sys_reset_n, ready, fault, lock_lost, retry_cnt}
    function automatic logic [6:0] vec(input bit pr, input bit sr, input bit rd,
                                       input bit ft, input bit ll, input logic [1:0] rc);
        return {pr, sr, rd, ft, ll, rc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_span(input int a, input int b, input string tag, input logic [6:0] v);
        exp_t e;
        for (int c = a; c <= b; c++) begin
            e.cyc = c;
            e.tag = tag;
            e.v   = v;
            sb.push_back(e);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, {25'd0, ov}, {25'd0, sb[i].v});
                sb.delete(i);
            end
        end
    end

    initial begin
        int r, t, f, d, s, p, guard;
        reset_n    = 1'b1;
        pll_locked = 1'b0;
        sw_relock  = 1'b0;
        #2 reset_n = 1'b0;
        #2 chk("async_rst", {25'd0, ov}, {25'd0, vec(1, 0, 0, 0, 0, 0)});

        // nominal lock
        to_cyc(3);
        r = cyc;
        reset_n = 1'b1;
        push_span(r + 1,  r + 3,  "nom_pllrst", vec(1, 0, 0, 0, 0, 0));
        push_span(r + 4,  r + 19, "nom_wait",   vec(0, 0, 0, 0, 0, 0));
        push_span(r + 20, r + 24, "nom_run",    vec(0, 1, 1, 0, 0, 0));
        to_cyc(r + 10);
        pll_locked = 1'b1;

        // loss of lock in RUN, then re-lock with lock_lost sticky
        to_cyc(r + 25);
        t = cyc;
        pll_locked = 1'b0;
        push_span(t + 1,  t + 2,  "loss_hold",   vec(0, 1, 1, 0, 0, 0));
        push_span(t + 3,  t + 6,  "loss_pllrst", vec(1, 0, 0, 0, 1, 0));
        push_span(t + 7,  t + 18, "loss_wait",   vec(0, 0, 0, 0, 1, 0));
        push_span(t + 19, t + 23, "relock_run",  vec(0, 1, 1, 0, 1, 0));
        to_cyc(t + 9);
        pll_locked = 1'b1;

        // sw_relock on the cycle locked_s falls, then lock never returns
        to_cyc(t + 24);
        t = cyc;
        pll_locked = 1'b0;
        push_span(t + 1, t + 2, "swl_hold", vec(0, 1, 1, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            p = t + 3 + 24 * k;
            push_span(p,     p + 3,  "to_pllrst", vec(1, 0, 0, 0, 0, 2'(k)));
            push_span(p + 4, p + 23, "to_wait",   vec(0, 0, 0, 0, 0, 2'(k)));
        end
        push_span(t + 75, t + 85, "fault_hold", vec(1, 0, 0, 1, 0, 2));
        to_cyc(t + 2);
        sw_relock = 1'b1;
        to_cyc(t + 3);
        sw_relock = 1'b0;

        // clear FAULT, then debounce a one-cycle lock glitch
        to_cyc(t + 86);
        f = cyc;
        d = f + 7;
        sw_relock = 1'b1;
        push_span(f + 1,  f + 4,  "clr_pllrst", vec(1, 0, 0, 0, 0, 0));
        push_span(f + 5,  d + 15, "deb_wait",   vec(0, 0, 0, 0, 0, 0));
        push_span(d + 16, d + 20, "deb_run",    vec(0, 1, 1, 0, 0, 0));
        to_cyc(f + 1);
        sw_relock = 1'b0;
        to_cyc(d);
        pll_locked = 1'b1;
        to_cyc(d + 5);
        pll_locked = 1'b0;
        to_cyc(d + 6);
        pll_locked = 1'b1;

        // re-sequence with lock held, then async reset inside STABILIZE
        to_cyc(d + 21);
        s = cyc;
        sw_relock = 1'b1;
        push_span(s + 1, s + 4, "stb_pllrst", vec(1, 0, 0, 0, 0, 0));
        push_span(s + 5, s + 8, "stb_wait",   vec(0, 0, 0, 0, 0, 0));
        to_cyc(s + 1);
        sw_relock = 1'b0;
        to_cyc(s + 8);
        #5 reset_n = 1'b0;
        #1 chk("async_rst_mid", {25'd0, ov}, {25'd0, vec(1, 0, 0, 0, 0, 0)});
        repeat (3) @(negedge clk);
        chk("rst_held", {25'd0, ov}, {25'd0, vec(1, 0, 0, 0, 0, 0)});

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
